// File: rtl/maxnet_input_loader.sv
// Ping-pong input loader for the Maxnet datapath: packs four streamed words into a
// set, presents it on four buses and holds it until the datapath reports completion.
module maxnet_input_loader #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            set_valid,
  input  logic            set_ack,
  input  logic            proc_done,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic [XLEN-1:0] readData3,
  output logic [XLEN-1:0] readData4,
  output logic            busy,
  output logic [1:0]      sets_pending
);

  localparam int unsigned NUM_BANKS = 2;
  localparam int unsigned NUM_WORDS = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_BUSY    = 2'd3
  } bank_state_e;

  bank_state_e     state_q [NUM_BANKS];
  bank_state_e     state_d [NUM_BANKS];
  logic [XLEN-1:0] mem_q   [NUM_BANKS][NUM_WORDS];
  logic [XLEN-1:0] mem_d   [NUM_BANKS][NUM_WORDS];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      wr_cnt_q,  wr_cnt_d;

  logic            wr_fire_c;
  logic            rd_present_c;

  // State register; flush clears everything exactly like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= BANK_EMPTY;
        for (int w = 0; w < NUM_WORDS; w++) begin
          mem_q[b][w] <= '0;
        end
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 2'd0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_d[b];
        for (int w = 0; w < NUM_WORDS; w++) begin
          mem_q[b][w] <= mem_d[b][w];
        end
      end
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Status decode from registered state only
  always_comb begin
    in_ready     = (state_q[wr_bank_q] == BANK_EMPTY) || (state_q[wr_bank_q] == BANK_FILLING);
    set_valid    = (state_q[rd_bank_q] == BANK_FULL);
    busy         = (state_q[rd_bank_q] == BANK_BUSY);
    rd_present_c = set_valid || busy;
    sets_pending = 2'((state_q[0] != BANK_EMPTY) ? 1 : 0)
                 + 2'((state_q[1] != BANK_EMPTY) ? 1 : 0);
    wr_fire_c    = in_valid && in_ready;
  end

  // Next-state: write side and read side touch different banks, so both may act in one cycle
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;

    if (wr_fire_c) begin
      mem_d[wr_bank_q][wr_cnt_q] = in_data;
      wr_cnt_d = 2'(wr_cnt_q + 2'd1);
      if (wr_cnt_q == 2'd3) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        state_d[wr_bank_q] = BANK_FILLING;
      end
    end

    if (set_valid && set_ack) begin
      state_d[rd_bank_q] = BANK_BUSY;
    end else if (busy && proc_done) begin
      state_d[rd_bank_q] = BANK_EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end
  end

  // Presented set: zero unless the read bank holds a complete set
  always_comb begin
    readData1 = rd_present_c ? mem_q[rd_bank_q][0] : '0;
    readData2 = rd_present_c ? mem_q[rd_bank_q][1] : '0;
    readData3 = rd_present_c ? mem_q[rd_bank_q][2] : '0;
    readData4 = rd_present_c ? mem_q[rd_bank_q][3] : '0;
  end

endmodule

// File: tb/tb_maxnet_input_loader.sv
// Directed bench for maxnet_input_loader: stimulus pushes expected sets into a queue,
// a monitor pops and compares whenever a new set is presented.
module tb_maxnet_input_loader;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, set_ack, proc_done;
  logic [XLEN-1:0] in_data;
  logic            in_ready, set_valid, busy;
  logic [1:0]      sets_pending;
  logic [XLEN-1:0] readData1, readData2, readData3, readData4;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;
  logic [4*XLEN-1:0] exp_q[$];

  maxnet_input_loader #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .set_valid(set_valid), .set_ack(set_ack), .proc_done(proc_done),
    .readData1(readData1), .readData2(readData2), .readData3(readData3), .readData4(readData4),
    .busy(busy), .sets_pending(sets_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, XLEN'(in_ready), 32'd1);
    chk({tag, ".set_valid"}, XLEN'(set_valid), 32'd0);
    chk({tag, ".busy"}, XLEN'(busy), 32'd0);
    chk({tag, ".sets_pending"}, XLEN'(sets_pending), 32'd0);
    chk({tag, ".readData1"}, readData1, 32'd0);
    chk({tag, ".readData4"}, readData4, 32'd0);
  endtask

  task automatic expect_set(input logic [XLEN-1:0] w0, input logic [XLEN-1:0] w1,
                            input logic [XLEN-1:0] w2, input logic [XLEN-1:0] w3);
    exp_q.push_back({w0, w1, w2, w3});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer one word and hold it until accepted (bounded)
  task automatic push(input logic [XLEN-1:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL push_timeout: word 0x%08h not accepted, in_ready=%0b required 1", w, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    set_ack = 1'b1;
    @(posedge clk);
    #1 set_ack = 1'b0;
  endtask

  task automatic pulse_done();
    proc_done = 1'b1;
    @(posedge clk);
    #1 proc_done = 1'b0;
  endtask

  // Monitor: compare each newly presented set against the scoreboard
  initial begin : monitor
    logic prev_sv;
    logic [4*XLEN-1:0] exp_set, act_set;
    prev_sv = 1'b0;
    forever begin
      @(negedge clk);
      if (set_valid && !prev_sv) begin
        act_set = {readData1, readData2, readData3, readData4};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL set_unexpected: got %h, none expected", act_set);
        end else begin
          exp_set = exp_q.pop_front();
          if (act_set === exp_set) n_pass++;
          else $display("FAIL set_words: got %h expected %h", act_set, exp_set);
        end
      end
      prev_sv = set_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    set_ack = 1'b0; proc_done = 1'b0;

    // 1: reset values, then a basic set with in_valid held high
    do_reset();
    chk_idle("reset");
    stalls = 0;
    expect_set(32'd5, 32'hFFFF_FFFD, 32'd9, 32'd2);
    push(32'd5); push(-32'sd3); push(32'd9); push(32'd2);
    chk("t1.stalls", XLEN'(stalls), 32'd0);
    chk("t1.set_valid", XLEN'(set_valid), 32'd1);
    chk("t1.sets_pending", XLEN'(sets_pending), 32'd1);
    chk("t1.in_ready", XLEN'(in_ready), 32'd1);
    pulse_ack();
    chk("t1.busy", XLEN'(busy), 32'd1);
    chk("t1.sv_after_ack", XLEN'(set_valid), 32'd0);
    chk("t1.rd2_busy", readData2, 32'hFFFF_FFFD);
    pulse_done();
    chk("t1.busy_done", XLEN'(busy), 32'd0);
    chk("t1.pending_done", XLEN'(sets_pending), 32'd0);

    // 2: both banks fill, 9th word waits until proc_done frees bank0
    do_reset();
    expect_set(32'h11, 32'h12, 32'h13, 32'h14);
    expect_set(32'h15, 32'h16, 32'h17, 32'h18);
    for (int i = 0; i < 8; i++) push(XLEN'(32'h11 + i));
    chk("t2.in_ready_full", XLEN'(in_ready), 32'd0);
    chk("t2.pending2", XLEN'(sets_pending), 32'd2);
    in_data = 32'h19; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2.in_ready_held", XLEN'(in_ready), 32'd0);
    chk("t2.rd1_bank0", readData1, 32'h11);
    pulse_ack();
    chk("t2.busy", XLEN'(busy), 32'd1);
    chk("t2.in_ready_busy", XLEN'(in_ready), 32'd0);
    pulse_done();
    chk("t2.in_ready_freed", XLEN'(in_ready), 32'd1);
    chk("t2.set_valid_b1", XLEN'(set_valid), 32'd1);
    chk("t2.rd1_b1", readData1, 32'h15);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("t2.pending_after9", XLEN'(sets_pending), 32'd2);
    expect_set(32'h19, 32'h1A, 32'h1B, 32'h1C);
    push(32'h1A); push(32'h1B); push(32'h1C);
    pulse_ack();
    pulse_done();
    chk("t2.sv_c", XLEN'(set_valid), 32'd1);
    pulse_ack();
    pulse_done();
    chk("t2.pending_end", XLEN'(sets_pending), 32'd0);

    // 3: stray set_ack / proc_done are ignored
    do_reset();
    pulse_ack();
    pulse_done();
    chk_idle("t3.idle");
    expect_set(32'h21, 32'h22, 32'h23, 32'h24);
    push(32'h21); push(32'h22); push(32'h23); push(32'h24);
    pulse_done();
    chk("t3.sv_kept", XLEN'(set_valid), 32'd1);
    chk("t3.busy_kept", XLEN'(busy), 32'd0);
    chk("t3.pending_kept", XLEN'(sets_pending), 32'd1);
    chk("t3.rd3_kept", readData3, 32'h23);
    pulse_ack();
    pulse_ack();
    chk("t3.busy_2ack", XLEN'(busy), 32'd1);
    chk("t3.pending_2ack", XLEN'(sets_pending), 32'd1);
    pulse_done();

    // 4: bank1 completes in the same cycle proc_done frees bank0
    do_reset();
    expect_set(32'h31, 32'h32, 32'h33, 32'h34);
    push(32'h31); push(32'h32); push(32'h33); push(32'h34);
    pulse_ack();
    expect_set(32'h41, 32'h42, 32'h43, 32'h44);
    push(32'h41); push(32'h42); push(32'h43);
    in_data = 32'h44; in_valid = 1'b1; proc_done = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; proc_done = 1'b0;
    chk("t4.set_valid", XLEN'(set_valid), 32'd1);
    chk("t4.busy", XLEN'(busy), 32'd0);
    chk("t4.in_ready", XLEN'(in_ready), 32'd1);
    chk("t4.pending", XLEN'(sets_pending), 32'd1);
    chk("t4.rd4", readData4, 32'h44);

    // 5: rst mid-fill, flush while busy, stale proc_done ignored
    do_reset();
    push(32'h51); push(32'h52);
    do_reset();
    chk_idle("t5.rst");
    expect_set(32'h61, 32'h62, 32'h63, 32'h64);
    push(32'h61); push(32'h62); push(32'h63); push(32'h64);
    pulse_ack();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk_idle("t5.flush");
    pulse_done();
    chk_idle("t5.stale_done");
    expect_set(32'h71, 32'h72, 32'h73, 32'h74);
    push(32'h71); push(32'h72); push(32'h73); push(32'h74);
    chk("t5.pending_fresh", XLEN'(sets_pending), 32'd1);

    // 6: source stalls every other cycle
    do_reset();
    expect_set(32'h81, 32'h82, 32'h83, 32'h84);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = XLEN'(32'h81 + i / 2);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("t6.pending", XLEN'(sets_pending), 32'd1);
    chk("t6.in_ready", XLEN'(in_ready), 32'd1);
    chk("t6.set_valid", XLEN'(set_valid), 32'd1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", XLEN'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maxnet_input_loader.md
Name: maxnet_input_loader

Overview:
- Upstream feeder for the Maxnet datapath. Replaces the fixed-content data memory as the source of the four candidate values.
- Accepts a stream of XLEN-bit words over a valid/ready handshake and packs every four consecutive words into one input set.
- Presents each complete set on four parallel buses and holds it stable until the datapath reports completion.
- Ping-pong double buffer: the next set loads while the current set is being processed.

Parameters:
- XLEN, 32, width of each data word and of each output bus.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  XLEN  incoming word; two's complement, passed through unmodified.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a word this cycle.
- flush  input  1  synchronous clear of both banks (same effect as rst, except that rst has priority).
- set_valid  output  1  a complete set is available and not yet started.
- set_ack  input  1  the controller starts processing the presented set.
- proc_done  input  1  the datapath finished the active set; one-cycle pulse.
- readData1..readData4  output  XLEN each  words 0..3 of the presented/active set.
- busy  output  1  a set is currently being processed.
- sets_pending  output  2  number of banks that are not EMPTY (0..2).

Behaviour:
- Storage: two banks, bank0 and bank1, each 4 x XLEN registers.
  - Each bank has a state: EMPTY, FILLING, FULL or BUSY.
  - wr_bank pointer, rd_bank pointer, and a 2-bit word counter wr_cnt.
- Reset/flush values:
  - Both banks EMPTY; wr_bank=0; rd_bank=0; wr_cnt=0.
  - in_ready=1, set_valid=0, busy=0, sets_pending=0.
  - readData1..4=0. Bank contents are cleared to 0.
  - rst or flush mid-fill or mid-processing discards all data; a later proc_done for the discarded set is ignored.
- Write side:
  - in_ready = (state[wr_bank] is EMPTY or FILLING). It is combinational from registered state only, never from in_valid.
  - A word transfers when in_valid && in_ready. The word goes to bank[wr_bank][wr_cnt] and wr_cnt increments.
    - EMPTY→FILLING on the first word.
  - On the 4th word (wr_cnt=3): wr_cnt wraps to 0, state becomes FULL and wr_bank toggles.
  - Order is fixed: the first word accepted lands on readData1, the fourth on readData4.
  - When in_ready=0, in_data is ignored; the source must hold the word.
- Read side:
  - set_valid = (state[rd_bank]==FULL).
  - On set_valid && set_ack: the bank becomes BUSY at the next edge.
  - set_ack when set_valid=0 is ignored.
  - busy = (state[rd_bank]==BUSY).
  - proc_done while busy: the bank becomes EMPTY, its contents are retained but unused, and rd_bank toggles.
  - proc_done when not busy is ignored.
  - readData1..4 = words of bank[rd_bank] when its state is FULL or BUSY, else 0. They are stable for the whole BUSY period.
- Latency:
  - 4th word accepted at edge k → set_valid=1 in the cycle after edge k.
  - set_ack at edge k → busy=1 and set_valid=0 after edge k.
  - proc_done at edge k → the freed bank is writable after edge k. If the other bank is FULL, set_valid=1 after edge k.
- Simultaneous events:
  - Completing a write on one bank and proc_done on the other in the same cycle: both take effect.
  - Same-bank write and read conflicts cannot occur, because a bank is never FILLING and FULL/BUSY at once.
- sets_pending = count of banks whose state is not EMPTY. It updates with the state registers.
- No arithmetic on data. Widths are preserved exactly.

Test Plan:
- Reset, then stream 5, -3, 9, 2 with in_valid continuously high → in_ready=1 throughout. set_valid=1 one cycle after the 4th word. readData1..4 = 5, 0xFFFFFFFD, 9, 2. sets_pending=1.
- Ping-pong backpressure: stream 8 words with no set_ack → in_ready drops after the 8th word and a 9th word stays pending. Then set_ack, then a proc_done pulse → in_ready=1 the cycle after proc_done. The 9th word is accepted into bank0, and set_valid=1 presenting words 5..8.
- set_ack with set_valid=0, and proc_done with busy=0 → no state change. sets_pending, in_ready and outputs are unchanged.
- Simultaneous events: bank1 completes (4th word) in the same cycle proc_done frees bank0 → after the edge bank0 is EMPTY and bank1 is FULL, set_valid=1 showing bank1's words, and in_ready=1.
- Reset mid-operation: rst asserted after 2 words, and separately flush while busy → all outputs return to reset values. A following proc_done is ignored, and the next 4 words form a fresh set in bank0.
- Stall on the source side: in_valid toggled 1,0,1,0… over 8 cycles → exactly 4 words are captured, in order, with no duplicates.
